uart_rx_param: RTL and testbench

Parametrised RS232 receiver, the successor to the fixed 8N1 receiver used in mini_spart.
- Configurable data width, oversampling ratio, optional even/odd parity and 1 or 2 stop bits.
- Adds false-start rejection, parity and framing error flags, and a holding register with overrun detection, so reception continues while software has not yet read.
- Sits between the RxD pin and the SPART bus interface; driven by the shared baud generator's oversample tick.

---
 rtl/uart_rx_param_if.sv | 34 +++
 rtl/uart_rx_param.sv | 170 +++++++++++++++++
 tb/tb_uart_rx_param.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_param_if.sv
// Purpose: bundles the receiver's serial input, baud tick, read strobe and
//          holding-register outputs into one port.
// Signals:
//   RxD        serial line (idles high)
//   Baud       one-clk oversample tick
//   rd_rx      one-clk read strobe acknowledging the holding register
//   RxD_data   holding register, last completed frame
//   RDA        holding register valid
//   parity_err parity mismatch on the held frame
//   frame_err  stop bit sampled low on the held frame
//   overrun    a frame completed while RDA was already set
// Modports: master = bus/line side, slave = receiver.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 RxD;
  logic                 Baud;
  logic                 rd_rx;
  logic [DATA_BITS-1:0] RxD_data;
  logic                 RDA;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output RxD, Baud, rd_rx,
    input  RxD_data, RDA, parity_err, frame_err, overrun
  );

  modport slave (
    input  RxD, Baud, rd_rx,
    output RxD_data, RDA, parity_err, frame_err, overrun
  );
endinterface

// File: rtl/uart_rx_param.sv
// Purpose: parametrised RS232 receiver with false-start rejection, parity and
//          framing checks, and a holding register with overrun detection.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  uart_rx_param_if.slave: RxD, Baud, rd_rx in; RxD_data, RDA,
//        parity_err, frame_err, overrun out
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic            clk,
  input  logic            rst,
  uart_rx_param_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int             TW        = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0]  HALF_T    = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0]  FULL_T    = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]     LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]     LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic           ODD       = (PARITY_ODD != 0);
  localparam logic           HAS_PAR   = (PARITY_EN != 0);

  state_t               r_state, w_state_nxt;
  logic [1:0]           r_sync;
  logic                 r_prev;
  logic [TW-1:0]        r_tick;
  logic [3:0]           r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_perr, r_ferr;
  logic                 r_rda, r_perr_o, r_ferr_o, r_ovr;

  logic w_rx, w_fall, w_half, w_full;
  logic w_tick_clr, w_bit_clr, w_bit_inc, w_start_ok;
  logic w_shift, w_par_smp, w_stop_smp, w_done;

  assign w_rx   = r_sync[1];
  assign w_fall = r_prev & ~r_sync[1];
  // Samples land on the Baud tick that completes the half/full bit count.
  assign w_half = bus.Baud && (r_tick == HALF_T);
  assign w_full = bus.Baud && (r_tick == FULL_T);

  always_comb begin
    w_state_nxt = r_state;
    w_tick_clr  = 1'b0;
    w_bit_clr   = 1'b0;
    w_bit_inc   = 1'b0;
    w_start_ok  = 1'b0;
    w_shift     = 1'b0;
    w_par_smp   = 1'b0;
    w_stop_smp  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_state_nxt = START;
          w_tick_clr  = 1'b1;
        end
      end
      START: begin
        if (w_half) begin
          w_tick_clr = 1'b1;
          if (w_rx) begin
            // Line back high at bit centre: glitch, not a start bit.
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = DATA;
            w_bit_clr   = 1'b1;
            w_start_ok  = 1'b1;
          end
        end
      end
      DATA: begin
        if (w_full) begin
          w_tick_clr = 1'b1;
          w_shift    = 1'b1;
          if (r_bit == LAST_DATA) begin
            w_bit_clr   = 1'b1;
            w_state_nxt = HAS_PAR ? PARITY : STOP;
          end else begin
            w_bit_inc = 1'b1;
          end
        end
      end
      PARITY: begin
        if (w_full) begin
          w_tick_clr  = 1'b1;
          w_par_smp   = 1'b1;
          w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (w_full) begin
          w_tick_clr = 1'b1;
          w_stop_smp = 1'b1;
          if (r_bit == LAST_STOP) begin
            // Back to IDLE mid-stop-bit so the next start edge is not missed.
            w_done      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_bit_inc = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync   <= 2'b11;
      r_prev   <= 1'b1;
      r_state  <= IDLE;
      r_tick   <= '0;
      r_bit    <= '0;
      r_data   <= '0;
      r_rda    <= 1'b0;
      r_perr_o <= 1'b0;
      r_ferr_o <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], bus.RxD};
      r_prev  <= r_sync[1];
      r_state <= w_state_nxt;
      if (w_tick_clr)    r_tick <= '0;
      else if (bus.Baud) r_tick <= r_tick + 1'b1;
      if (w_bit_clr)      r_bit <= '0;
      else if (w_bit_inc) r_bit <= r_bit + 1'b1;
      if (w_done) begin
        r_data   <= r_shift;
        r_rda    <= 1'b1;
        r_perr_o <= r_perr;
        r_ferr_o <= r_ferr | ~w_rx;
        // A coincident read acknowledges the old frame, so no overrun.
        r_ovr    <= ~bus.rd_rx & (r_ovr | r_rda);
      end else if (bus.rd_rx) begin
        r_rda    <= 1'b0;
        r_perr_o <= 1'b0;
        r_ferr_o <= 1'b0;
        r_ovr    <= 1'b0;
      end
    end
  end

  // Per-frame datapath: shift register and error flags, rebuilt each frame.
  always_ff @(posedge clk) begin
    if (w_shift) r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
    if (w_start_ok) begin
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      if (w_par_smp)           r_perr <= ((^r_shift) ^ w_rx) != ODD;
      if (w_stop_smp && !w_rx) r_ferr <= 1'b1;
    end
  end

  assign bus.RxD_data   = r_data;
  assign bus.RDA        = r_rda;
  assign bus.parity_err = r_perr_o;
  assign bus.frame_err  = r_ferr_o;
  assign bus.overrun    = r_ovr;

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       baud = 1'b0;
  logic [1:0] bcnt = 2'd0;
  logic       rxd [4];
  logic       rd  [4];
  logic [8:0] dat [4];
  logic       rda [4];
  logic       pe  [4];
  logic       fe  [4];
  logic       ov  [4];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         k;
    logic [8:0] d;
    logic       pe;
    logic       fe;
    logic       ov;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  // Baud tick once every 4 clocks.
  always @(posedge clk) begin
    bcnt <= bcnt + 2'd1;
    baud <= (bcnt == 2'd3);
  end

  uart_rx_param_if #(.DATA_BITS(8)) if0 ();
  uart_rx_param_if #(.DATA_BITS(8)) if1 ();
  uart_rx_param_if #(.DATA_BITS(8)) if2 ();
  uart_rx_param_if #(.DATA_BITS(7)) if3 ();

  assign if0.RxD = rxd[0];  assign if0.rd_rx = rd[0];  assign if0.Baud = baud;
  assign if1.RxD = rxd[1];  assign if1.rd_rx = rd[1];  assign if1.Baud = baud;
  assign if2.RxD = rxd[2];  assign if2.rd_rx = rd[2];  assign if2.Baud = baud;
  assign if3.RxD = rxd[3];  assign if3.rd_rx = rd[3];  assign if3.Baud = baud;

  assign dat[0] = {1'b0, if0.RxD_data};
  assign dat[1] = {1'b0, if1.RxD_data};
  assign dat[2] = {1'b0, if2.RxD_data};
  assign dat[3] = {2'b00, if3.RxD_data};
  assign rda[0] = if0.RDA;  assign pe[0] = if0.parity_err;  assign fe[0] = if0.frame_err;  assign ov[0] = if0.overrun;
  assign rda[1] = if1.RDA;  assign pe[1] = if1.parity_err;  assign fe[1] = if1.frame_err;  assign ov[1] = if1.overrun;
  assign rda[2] = if2.RDA;  assign pe[2] = if2.parity_err;  assign fe[2] = if2.frame_err;  assign ov[2] = if2.overrun;
  assign rda[3] = if3.RDA;  assign pe[3] = if3.parity_err;  assign fe[3] = if3.frame_err;  assign ov[3] = if3.overrun;

  uart_rx_param #(.DATA_BITS(8)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  uart_rx_param #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  uart_rx_param #(.DATA_BITS(8), .STOP_BITS(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
  uart_rx_param #(.DATA_BITS(7)) u_dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [8:0] d, input logic p, input logic f, input logic o);
    exp_t e;
    e.k = k; e.d = d; e.pe = p; e.fe = f; e.ov = o;
    q.push_back(e);
  endtask

  // Drives one frame, one bit every 64 clocks. rd_done pulses rd_rx in the
  // completion cycle: the last stop sample is the (8 + 16*(bits after start))-th
  // Baud tick seen after the third clock edge following the start edge.
  task automatic send(input int k, input logic [8:0] d, input int nb, input int pen,
                      input logic pb, input int ns, input logic s2, input bit rd_done,
                      input int rst_bit);
    logic b[16];
    int   n, bc, nt;
    n = 0;
    b[n] = 1'b0; n++;
    for (int i = 0; i < nb; i++) begin b[n] = d[i]; n++; end
    if (pen != 0) begin b[n] = pb; n++; end
    b[n] = 1'b1; n++;
    if (ns == 2) begin b[n] = s2; n++; end
    nt = 8 + 16 * (n - 1);
    bc = 0;
    for (int c = 0; c < 64 * n; c++) begin
      @(negedge clk);
      rxd[k] = b[c / 64];
      rd[k]  = 1'b0;
      if (c >= 3 && baud) begin
        bc++;
        if (bc == nt && rd_done) rd[k] = 1'b1;
      end
      if (rst_bit >= 0 && c == 64 * (1 + rst_bit) + 32) begin
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        rxd[k] = 1'b1;
        return;
      end
    end
    rd[k]  = 1'b0;
    rxd[k] = 1'b1;
  endtask

  task automatic read_clear(input int k);
    @(negedge clk);
    rd[k] = 1'b1;
    @(negedge clk);
    rd[k] = 1'b0;
    chk($sformatf("read_clr_dut%0d", k), {28'd0, rda[k], pe[k], fe[k], ov[k]}, 32'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d frames outstanding, expected 0", q.size());
      q.delete();
    end
  endtask

  // Monitor: a frame is presented when RDA rises, when held data changes
  // while RDA is set, or when overrun rises.
  initial begin
    logic [8:0] pd[4];
    logic       prda[4];
    logic       pov[4];
    for (int k = 0; k < 4; k++) begin pd[k] = '0; prda[k] = 1'b0; pov[k] = 1'b0; end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if ((rda[k] === 1'b1 && prda[k] === 1'b0) ||
            (rda[k] === 1'b1 && dat[k] !== pd[k]) ||
            (ov[k] === 1'b1 && pov[k] === 1'b0)) begin
          int idx;
          idx = -1;
          foreach (q[i]) if (idx < 0 && q[i].k == k) idx = i;
          checks++;
          if (idx < 0) begin
            errors++;
            $display("FAIL unexpected_frame_dut%0d: got data=%h pe=%b fe=%b ov=%b, expected no frame",
                     k, dat[k], pe[k], fe[k], ov[k]);
          end else begin
            if ({dat[k], pe[k], fe[k], ov[k], rda[k]} !==
                {q[idx].d, q[idx].pe, q[idx].fe, q[idx].ov, 1'b1}) begin
              errors++;
              $display("FAIL frame_dut%0d: got data=%h pe=%b fe=%b ov=%b rda=%b, expected data=%h pe=%b fe=%b ov=%b rda=1",
                       k, dat[k], pe[k], fe[k], ov[k], rda[k], q[idx].d, q[idx].pe, q[idx].fe, q[idx].ov);
            end
            q.delete(idx);
          end
        end
        pd[k]   = dat[k];
        prda[k] = rda[k];
        pov[k]  = ov[k];
      end
    end
  end

  initial begin
    for (int k = 0; k < 4; k++) begin rxd[k] = 1'b1; rd[k] = 1'b0; end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++)
      chk($sformatf("reset_dut%0d", k), {19'd0, dat[k], rda[k], pe[k], fe[k], ov[k]}, 32'd0);
    repeat (20) @(negedge clk);

    // 8N1 basic frame, then read.
    push(0, 9'h0A5, 0, 0, 0);
    send(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1, 1'b0, -1);
    drain();
    read_clear(0);

    // False start: low for 3 ticks only.
    @(negedge clk); rxd[0] = 1'b0;
    repeat (12) @(negedge clk);
    rxd[0] = 1'b1;
    repeat (200) @(negedge clk);
    chk("false_start_rda", {31'd0, rda[0]}, 32'd0);
    push(0, 9'h05A, 0, 0, 0);
    send(0, 9'h05A, 8, 0, 1'b0, 1, 1'b1, 1'b0, -1);
    drain();
    read_clear(0);

    // Even parity on 0x37 (five ones -> correct bit is 1).
    push(1, 9'h037, 1, 0, 0);
    send(1, 9'h037, 8, 1, 1'b0, 1, 1'b1, 1'b0, -1);
    drain();
    read_clear(1);
    push(1, 9'h037, 0, 0, 0);
    send(1, 9'h037, 8, 1, 1'b1, 1, 1'b1, 1'b0, -1);
    drain();
    read_clear(1);

    // Two stop bits, second one low -> framing error.
    push(2, 9'h055, 0, 1, 0);
    send(2, 9'h055, 8, 0, 1'b0, 2, 1'b0, 1'b0, -1);
    drain();
    read_clear(2);
    push(2, 9'h00F, 0, 0, 0);
    send(2, 9'h00F, 8, 0, 1'b0, 2, 1'b1, 1'b0, -1);
    drain();
    read_clear(2);

    // Back-to-back without read -> overrun, newest data held.
    push(0, 9'h011, 0, 0, 0);
    send(0, 9'h011, 8, 0, 1'b0, 1, 1'b1, 1'b0, -1);
    push(0, 9'h022, 0, 0, 1);
    send(0, 9'h022, 8, 0, 1'b0, 1, 1'b1, 1'b0, -1);
    drain();
    read_clear(0);

    // Same, read coincident with second completion -> no overrun, RDA stays set.
    push(0, 9'h011, 0, 0, 0);
    send(0, 9'h011, 8, 0, 1'b0, 1, 1'b1, 1'b0, -1);
    push(0, 9'h022, 0, 0, 0);
    send(0, 9'h022, 8, 0, 1'b0, 1, 1'b1, 1'b1, -1);
    drain();
    chk("coincident_rda", {31'd0, rda[0]}, 32'd1);
    read_clear(0);

    // 7 data bits: hold a frame, reset mid-frame, then receive again.
    push(3, 9'h015, 0, 0, 0);
    send(3, 9'h015, 7, 0, 1'b0, 1, 1'b1, 1'b0, -1);
    drain();
    send(3, 9'h02A, 7, 0, 1'b0, 1, 1'b1, 1'b0, 4);
    chk("mid_frame_reset", {19'd0, dat[3], rda[3], pe[3], fe[3], ov[3]}, 32'd0);
    repeat (100) @(negedge clk);
    chk("post_reset_idle", {31'd0, rda[3]}, 32'd0);
    push(3, 9'h03C, 0, 0, 0);
    send(3, 9'h03C, 7, 0, 1'b0, 1, 1'b1, 1'b0, -1);
    drain();
    read_clear(3);

    repeat (20) @(negedge clk);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
